// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: digit table, blank pattern, decoder FSM state.
// The encoder indexes SEG_TABLE too, so both directions use one table.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Active-low {g,f,e,d,c,b,a} pattern for each hex digit, indexed by digit value.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   typedef logic [0:0] state_t;
   localparam state_t StEmpty = 1'b0;
   localparam state_t StFull  = 1'b1;

   typedef struct packed {
      logic       hit;
      logic [3:0] digit;
   } seg_dec_t;

   function automatic seg_dec_t seg_decode(input logic [6:0] pat);
      seg_dec_t res;
      res.hit   = 1'b0;
      res.digit = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (pat == SEG_TABLE[i]) begin
            res.hit   = 1'b1;
            res.digit = 4'(i);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Debounces the segment bus: a pattern qualifies once after STABLE_CYCLES+1 identical samples,
// and a repeat of the previously qualified pattern is suppressed until something else qualifies.
module seg7_stable_filter
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg_in,
   output logic       qualify,
   output logic [6:0] pattern
);

   localparam logic [7:0] CntMax = 8'(STABLE_CYCLES - 1);

   logic [6:0] seg_q, seg_d;
   logic [6:0] last_seg_q, last_seg_d;
   logic [7:0] stab_cnt_q, stab_cnt_d;
   logic       same;

   always_comb begin
      same       = (seg_in == seg_q);
      qualify    = same && (stab_cnt_q == CntMax) && (seg_q != last_seg_q);
      seg_d      = seg_q;
      stab_cnt_d = stab_cnt_q;
      last_seg_d = last_seg_q;
      if (!same) begin
         seg_d      = seg_in;
         stab_cnt_d = 8'd0;
      end else if (stab_cnt_q < CntMax) begin
         stab_cnt_d = stab_cnt_q + 8'd1;
      end
      if (qualify) begin
         last_seg_d = seg_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q      <= SEG_BLANK;
         stab_cnt_q <= 8'd0;
         last_seg_q <= SEG_BLANK;
      end else begin
         seg_q      <= seg_d;
         stab_cnt_q <= stab_cnt_d;
         last_seg_q <= last_seg_d;
      end
   end

   assign pattern = seg_q;

endmodule

// File: rtl/seg7_pattern_decoder.sv
// Decodes a debounced active-low segment bus back to a hex digit with a valid/ready output,
// flagging and counting patterns that are neither a digit nor blank.
module seg7_pattern_decoder
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned ERR_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       seg_in,
   input  logic             out_ready,
   input  logic             clr_flags,
   output logic [3:0]       value_out,
   output logic             value_valid,
   output logic             bad_pattern,
   output logic             overrun,
   output logic [ERR_W-1:0] err_cnt
);

   localparam logic [ERR_W-1:0] ErrMax = {ERR_W{1'b1}};
   localparam logic [ERR_W-1:0] ErrOne = ERR_W'(1);

   logic       qualify;
   logic [6:0] pattern;
   seg_dec_t   dec;
   logic       hit, illegal;

   state_t           state_q, state_d;
   logic [3:0]       value_q, value_d;
   logic             bad_q, bad_d;
   logic             overrun_q, overrun_d;
   logic [ERR_W-1:0] err_q, err_d;

   seg7_stable_filter #(
      .STABLE_CYCLES(STABLE_CYCLES)
   ) u_filter (
      .clk    (clk),
      .rst    (rst),
      .seg_in (seg_in),
      .qualify(qualify),
      .pattern(pattern)
   );

   always_comb begin
      dec     = seg_decode(pattern);
      hit     = qualify && dec.hit;
      illegal = qualify && !dec.hit && (pattern != SEG_BLANK);

      state_d   = state_q;
      value_d   = value_q;
      bad_d     = illegal;
      overrun_d = clr_flags ? 1'b0 : overrun_q;
      err_d     = clr_flags ? '0 : err_q;

      case (state_q)
         StEmpty: begin
            if (hit) begin
               value_d = dec.digit;
               state_d = StFull;
            end
         end
         StFull: begin
            // A hit coinciding with a transfer replaces the consumed digit, so it is no overrun.
            if (hit) begin
               value_d = dec.digit;
               if (!out_ready) overrun_d = 1'b1;
            end else if (out_ready) begin
               state_d = StEmpty;
            end
         end
         default: state_d = StEmpty;
      endcase

      if (illegal && (err_d != ErrMax)) begin
         err_d = err_d + ErrOne;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StEmpty;
         value_q   <= 4'd0;
         bad_q     <= 1'b0;
         overrun_q <= 1'b0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         value_q   <= value_d;
         bad_q     <= bad_d;
         overrun_q <= overrun_d;
         err_q     <= err_d;
      end
   end

   assign value_out   = value_q;
   assign value_valid = (state_q == StFull);
   assign bad_pattern = bad_q;
   assign overrun     = overrun_q;
   assign err_cnt     = err_q;

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Bench for seg7_pattern_decoder: run-length reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_seg7_pattern_decoder;

   localparam int unsigned S     = 4;
   localparam int unsigned ERR_W = 8;
   localparam logic [6:0]  BLANK = 7'b1111111;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [6:0]       seg_in = BLANK;
   logic             out_ready = 1'b0;
   logic             clr_flags = 1'b0;
   logic [3:0]       value_out;
   logic             value_valid;
   logic             bad_pattern;
   logic             overrun;
   logic [ERR_W-1:0] err_cnt;

   always #5 clk = ~clk;

   seg7_pattern_decoder #(
      .STABLE_CYCLES(S),
      .ERR_W        (ERR_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .seg_in     (seg_in),
      .out_ready  (out_ready),
      .clr_flags  (clr_flags),
      .value_out  (value_out),
      .value_valid(value_valid),
      .bad_pattern(bad_pattern),
      .overrun    (overrun),
      .err_cnt    (err_cnt)
   );

   logic [6:0] ref_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
   endtask

   // Reference model: a pattern reports when its run of identical samples reaches S+1,
   // unless it equals the last pattern that reported.
   logic [6:0] m_prev = BLANK;
   logic [6:0] m_last = BLANK;
   int         m_run = 0;
   bit         m_valid = 1'b0;
   logic [3:0] m_value = 4'd0;
   bit         m_bad = 1'b0;
   bit         m_ovr = 1'b0;
   int         m_err = 0;
   bit         live = 1'b0;

   always @(posedge clk) begin : model
      bit qual, hit, xfer;
      int d;
      if (rst) begin
         m_prev = BLANK; m_last = BLANK; m_run = 0;
         m_valid = 1'b0; m_value = 4'd0; m_bad = 1'b0; m_ovr = 1'b0; m_err = 0;
         live = 1'b1;
      end else begin
         xfer = m_valid && out_ready;
         if (seg_in == m_prev) begin
            if (m_run < 1000) m_run++;
         end else begin
            m_prev = seg_in;
            m_run  = 1;
         end
         qual = (m_run == int'(S) + 1) && (m_prev != m_last);
         hit = 1'b0;
         d   = 0;
         for (int i = 0; i < 16; i++) begin
            if (qual && ref_tab[i] == m_prev) begin
               hit = 1'b1;
               d   = i;
            end
         end
         if (qual) m_last = m_prev;
         m_bad = qual && !hit && (m_prev != BLANK);
         if (clr_flags) begin
            m_ovr = 1'b0;
            m_err = 0;
         end
         if (m_bad && m_err < (2 ** ERR_W) - 1) m_err++;
         if (hit && m_valid && !out_ready) m_ovr = 1'b1;
         if (hit) begin
            m_valid = 1'b1;
            m_value = d[3:0];
         end else if (xfer) begin
            m_valid = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (live) begin
         chk("model_valid",   32'(value_valid), 32'(m_valid));
         chk("model_value",   32'(value_out),   32'(m_value));
         chk("model_bad",     32'(bad_pattern), 32'(m_bad));
         chk("model_overrun", 32'(overrun),     32'(m_ovr));
         chk("model_err_cnt", 32'(err_cnt),     32'(m_err));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic [6:0] pat, input int n);
      seg_in = pat;
      tick(n);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_valid"},   32'(value_valid), 32'd0);
      chk({tag, "_value"},   32'(value_out),   32'd0);
      chk({tag, "_bad"},     32'(bad_pattern), 32'd0);
      chk({tag, "_overrun"}, 32'(overrun),     32'd0);
      chk({tag, "_err_cnt"}, 32'(err_cnt),     32'd0);
   endtask

   initial begin
      logic [6:0] p;
      int         r;
      int         len;

      // Reset state, then a single clean digit with the consumer ready.
      tick(2);
      chk_reset("reset");
      rst = 1'b0;
      out_ready = 1'b1;
      hold(7'b0100100, 4);
      chk("t1_not_yet", 32'(value_valid), 32'd0);
      tick(1);
      chk("t1_valid", 32'(value_valid), 32'd1);
      chk("t1_value", 32'(value_out), 32'd2);
      tick(1);
      chk("t1_consumed", 32'(value_valid), 32'd0);
      tick(6);
      chk("t1_no_repeat", 32'(value_valid), 32'd0);

      // Toggling faster than the filter never reports.
      repeat (4) begin
         hold(7'b0110000, 3);
         hold(7'b1111001, 3);
      end
      hold(7'b0110000, 3);
      chk("t2_no_valid", 32'(value_valid), 32'd0);
      chk("t2_no_err", 32'(err_cnt), 32'd0);
      hold(7'b1111001, 5);
      chk("t2_valid", 32'(value_valid), 32'd1);
      chk("t2_value", 32'(value_out), 32'd1);
      tick(1);

      // Overwrite while the consumer stalls.
      out_ready = 1'b0;
      hold(7'b0001000, 5);
      chk("t3_value_a", 32'(value_out), 32'hA);
      hold(7'b0000011, 5);
      chk("t3_value_b", 32'(value_out), 32'hB);
      chk("t3_overrun", 32'(overrun), 32'd1);
      out_ready = 1'b1;
      tick(1);
      chk("t3_drained", 32'(value_valid), 32'd0);
      tick(3);
      chk("t3_overrun_sticky", 32'(overrun), 32'd1);
      clr_flags = 1'b1;
      tick(1);
      clr_flags = 1'b0;
      chk("t3_overrun_clr", 32'(overrun), 32'd0);

      // Illegal patterns separated by blank, then counter saturation.
      hold(BLANK, 5);
      repeat (3) begin
         hold(7'b0111111, 5);
         chk("t4_bad_pulse", 32'(bad_pattern), 32'd1);
         tick(1);
         chk("t4_bad_once", 32'(bad_pattern), 32'd0);
         hold(BLANK, 5);
      end
      chk("t4_err3", 32'(err_cnt), 32'd3);
      chk("t4_valid", 32'(value_valid), 32'd0);
      repeat (150) begin
         hold(7'b0111111, 5);
         hold(7'b0111110, 5);
      end
      chk("t4_err_sat", 32'(err_cnt), 32'd255);

      // Hit on the same edge as a transfer.
      out_ready = 1'b0;
      hold(7'b0010010, 5);
      chk("t5_value5", 32'(value_out), 32'd5);
      seg_in = 7'b0000010;
      tick(4);
      out_ready = 1'b1;
      tick(1);
      chk("t5_valid", 32'(value_valid), 32'd1);
      chk("t5_value6", 32'(value_out), 32'd6);
      chk("t5_no_overrun", 32'(overrun), 32'd0);
      tick(1);
      chk("t5_drained", 32'(value_valid), 32'd0);

      // Reset mid-count, then reset while full.
      out_ready = 1'b0;
      hold(7'b1111000, 2);
      rst = 1'b1;
      tick(1);
      chk_reset("t6_mid");
      rst = 1'b0;
      tick(4);
      chk("t6_not_yet", 32'(value_valid), 32'd0);
      tick(1);
      chk("t6_valid", 32'(value_valid), 32'd1);
      chk("t6_value", 32'(value_out), 32'd7);
      rst = 1'b1;
      tick(1);
      chk_reset("t6_full");
      rst = 1'b0;
      tick(5);
      chk("t6_again", 32'(value_valid), 32'd1);
      chk("t6_again_value", 32'(value_out), 32'd7);

      // Randomized traffic against the model.
      repeat (400) begin
         r = $urandom_range(0, 99);
         if (r < 60) p = ref_tab[$urandom_range(0, 15)];
         else if (r < 75) p = BLANK;
         else p = 7'($urandom);
         seg_in = p;
         len = $urandom_range(1, 8);
         repeat (len) begin
            out_ready = 1'($urandom_range(0, 1));
            clr_flags = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            tick(1);
         end
      end
      rst = 1'b0;
      clr_flags = 1'b0;
      tick(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
